// File: rtl/decoder1_wrapper_if.sv
// rtl/decoder1_wrapper_if.sv - input, S and two data-branch handshake channels of the tree decoder
interface decoder1_wrapper_if #(
    parameter int WIDTH = 9
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out0_data;
    logic             out0_valid;
    logic             out0_ready;
    logic [WIDTH-1:0] out1_data;
    logic             out1_valid;
    logic             out1_ready;
    logic             s_data;
    logic             s_valid;
    logic             s_ready;

    modport slave (
        input  in_data, in_valid, out0_ready, out1_ready, s_ready,
        output in_ready, out0_data, out0_valid, out1_data, out1_valid, s_data, s_valid
    );

    modport master (
        output in_data, in_valid, out0_ready, out1_ready, s_ready,
        input  in_ready, out0_data, out0_valid, out1_data, out1_valid, s_data, s_valid
    );
endinterface

// File: rtl/decoder1_wrapper.sv
// rtl/decoder1_wrapper.sv - NoC tree node decoder: emits route select S and steers the packet to branch 0 or 1
module decoder1_wrapper #(
    parameter int              WIDTH  = 9,
    parameter int              ADDR_W = 4,
    parameter logic [ADDR_W-1:0] MASK = 4'b1000,
    parameter bit              LEAF   = 1'b0
) (
    input  logic                 CLK,
    input  logic                 _RESET,
    decoder1_wrapper_if.slave    bus
);
    typedef enum logic [1:0] {IDLE, BOTH_PEND, S_PEND, D_PEND} state_t;

    state_t state;
    logic   started;
    logic   sel;
    logic   d_valid;
    logic   d_ready;
    logic   s_done;
    logic   d_done;
    logic   accept;

    assign sel     = (|(bus.in_data[ADDR_W-1:0] & MASK)) ^ LEAF;
    assign d_valid = bus.out0_valid | bus.out1_valid;
    // Only the branch holding the data token is listened to.
    assign d_ready = bus.out1_valid ? bus.out1_ready : bus.out0_ready;
    assign s_done  = bus.s_valid & bus.s_ready;
    assign d_done  = d_valid & d_ready;

    // Ready when neither token will still be outstanding after this edge;
    // started holds it low until the first edge after reset release.
    assign bus.in_ready = started && !(bus.s_valid && !bus.s_ready) && !(d_valid && !d_ready);
    assign accept       = bus.in_valid && bus.in_ready;

    always_ff @(posedge CLK or negedge _RESET) begin
        if (!_RESET) begin
            state          <= IDLE;
            started        <= 1'b0;
            bus.s_valid    <= 1'b0;
            bus.s_data     <= 1'b0;
            bus.out0_valid <= 1'b0;
            bus.out0_data  <= '0;
            bus.out1_valid <= 1'b0;
            bus.out1_data  <= '0;
        end else begin
            started <= 1'b1;
            if (accept) begin
                state          <= BOTH_PEND;
                bus.s_valid    <= 1'b1;
                bus.s_data     <= sel;
                bus.out0_valid <= !sel;
                bus.out1_valid <= sel;
                if (sel) bus.out1_data <= bus.in_data;
                else     bus.out0_data <= bus.in_data;
            end else begin
                case (state)
                    BOTH_PEND: begin
                        if (s_done && d_done) begin
                            state          <= IDLE;
                            bus.s_valid    <= 1'b0;
                            bus.out0_valid <= 1'b0;
                            bus.out1_valid <= 1'b0;
                        end else if (s_done) begin
                            state       <= D_PEND;
                            bus.s_valid <= 1'b0;
                        end else if (d_done) begin
                            state          <= S_PEND;
                            bus.out0_valid <= 1'b0;
                            bus.out1_valid <= 1'b0;
                        end
                    end
                    S_PEND: begin
                        if (s_done) begin
                            state       <= IDLE;
                            bus.s_valid <= 1'b0;
                        end
                    end
                    D_PEND: begin
                        if (d_done) begin
                            state          <= IDLE;
                            bus.out0_valid <= 1'b0;
                            bus.out1_valid <= 1'b0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_decoder1_wrapper.sv
// tb/tb_decoder1_wrapper.sv - self-checking bench for decoder1_wrapper against a golden route model
module tb_decoder1_wrapper;
    logic CLK;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    decoder1_wrapper_if #(.WIDTH(9)) bus0 ();
    decoder1_wrapper_if #(.WIDTH(9)) bus1 ();

    decoder1_wrapper #(.WIDTH(9), .ADDR_W(4), .MASK(4'b1000), .LEAF(1'b0)) u_parent (
        .CLK(CLK), ._RESET(rst_n), .bus(bus0));
    decoder1_wrapper #(.WIDTH(9), .ADDR_W(4), .MASK(4'b1000), .LEAF(1'b1)) u_leaf (
        .CLK(CLK), ._RESET(rst_n), .bus(bus1));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic golden_sel(input logic [8:0] d, input bit leaf);
        int addr;
        addr = d % 16;
        return ((addr >= 8) ? 1'b1 : 1'b0) ^ leaf;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        bus0.in_valid = 1'b1; bus0.in_data = 9'h155;
        bus0.s_ready = 1'b1; bus0.out0_ready = 1'b1; bus0.out1_ready = 1'b1;
        bus1.in_valid = 1'b1; bus1.in_data = 9'h0AA;
        bus1.s_ready = 1'b1; bus1.out0_ready = 1'b1; bus1.out1_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK); #1;
            n_cmp++;
            if ({bus0.in_ready, bus0.s_valid, bus0.out0_valid, bus0.out1_valid,
                 bus1.in_ready, bus1.s_valid, bus1.out0_valid, bus1.out1_valid} !== 8'b0) begin
                n_err++;
                $display("FAIL reset_hold cycle %0d: got ready/valids %b%b%b%b %b%b%b%b want all 0", i,
                    bus0.in_ready, bus0.s_valid, bus0.out0_valid, bus0.out1_valid,
                    bus1.in_ready, bus1.s_valid, bus1.out0_valid, bus1.out1_valid);
            end
        end
        n_cmp++;
        if ({bus0.s_data, bus0.out0_data, bus0.out1_data} !== 19'b0) begin
            n_err++;
            $display("FAIL reset_data: got s=%b o0=%h o1=%h want 0 0 0", bus0.s_data, bus0.out0_data, bus0.out1_data);
        end
        @(negedge CLK);
        rst_n = 1'b1;
        bus0.in_valid = 1'b0; bus1.in_valid = 1'b0;
        #1;
        n_cmp++;
        if (bus0.in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL ready_before_edge: got %b want 0", bus0.in_ready);
        end
        @(negedge CLK); #1;
        n_cmp++;
        if (bus0.in_ready !== 1'b1 || bus1.in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL ready_after_release: got %b/%b want 1/1", bus0.in_ready, bus1.in_ready);
        end
    endtask

    task automatic test_route();
        @(negedge CLK);
        bus0.in_data = 9'h00A; bus0.in_valid = 1'b1; #1;
        n_cmp++;
        if (bus0.in_ready !== 1'b1) begin
            n_err++; $display("FAIL route_ready_a: got %b want 1", bus0.in_ready);
        end
        @(negedge CLK);
        bus0.in_data = 9'h1F5; #1;
        n_cmp++;
        if ({bus0.s_valid, bus0.s_data, bus0.out1_valid, bus0.out0_valid} !== 4'b1110 || bus0.out1_data !== 9'h00A) begin
            n_err++;
            $display("FAIL route_00A: got sv=%b s=%b v1=%b v0=%b o1=%h want 1 1 1 0 00a",
                bus0.s_valid, bus0.s_data, bus0.out1_valid, bus0.out0_valid, bus0.out1_data);
        end
        @(negedge CLK);
        bus0.in_valid = 1'b0; #1;
        n_cmp++;
        if ({bus0.s_valid, bus0.s_data, bus0.out0_valid, bus0.out1_valid} !== 4'b1010 ||
            bus0.out0_data !== 9'h1F5 || bus0.out1_data !== 9'h00A) begin
            n_err++;
            $display("FAIL route_1F5: got sv=%b s=%b v0=%b v1=%b o0=%h o1=%h want 1 0 1 0 1f5 00a",
                bus0.s_valid, bus0.s_data, bus0.out0_valid, bus0.out1_valid, bus0.out0_data, bus0.out1_data);
        end
    endtask

    task automatic test_leaf();
        @(negedge CLK);
        bus1.in_data = 9'h00A; bus1.in_valid = 1'b1;
        @(negedge CLK);
        bus1.in_valid = 1'b0; #1;
        n_cmp++;
        if ({bus1.s_valid, bus1.s_data, bus1.out0_valid, bus1.out1_valid} !== 4'b1010 || bus1.out0_data !== 9'h00A) begin
            n_err++;
            $display("FAIL leaf_00A: got sv=%b s=%b v0=%b v1=%b o0=%h want 1 0 1 0 00a",
                bus1.s_valid, bus1.s_data, bus1.out0_valid, bus1.out1_valid, bus1.out0_data);
        end
    endtask

    task automatic test_stall();
        int xfers;
        xfers = 0;
        @(negedge CLK);
        bus0.s_ready = 1'b0; bus0.out1_ready = 1'b1;
        bus0.in_data = 9'h108; bus0.in_valid = 1'b1;
        @(negedge CLK);
        bus0.in_valid = 1'b0; bus0.in_data = 9'h000;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge CLK);
            #1;
            if (bus0.out1_valid && bus0.out1_ready) xfers++;
            n_cmp++;
            if ({bus0.in_ready, bus0.s_valid, bus0.s_data} !== 3'b011) begin
                n_err++;
                $display("FAIL stall_hold cycle %0d: got rdy=%b sv=%b s=%b want 0 1 1", i,
                    bus0.in_ready, bus0.s_valid, bus0.s_data);
            end
        end
        @(negedge CLK);
        bus0.s_ready = 1'b1; #1;
        n_cmp++;
        if (bus0.in_ready !== 1'b1 || bus0.s_valid !== 1'b1) begin
            n_err++;
            $display("FAIL stall_release: got rdy=%b sv=%b want 1 1", bus0.in_ready, bus0.s_valid);
        end
        n_cmp++;
        if (xfers !== 1) begin
            n_err++;
            $display("FAIL stall_out1_count: got %0d want 1", xfers);
        end
        @(negedge CLK); #1;
        n_cmp++;
        if (bus0.s_valid !== 1'b0) begin
            n_err++; $display("FAIL stall_s_cleared: got %b want 0", bus0.s_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [8:0] pkts [3];
        logic       exp_s [3];
        logic       got_s, got_b;
        logic [8:0] got_d;
        pkts[0] = 9'h001; pkts[1] = 9'h008; pkts[2] = 9'h00F;
        exp_s[0] = 1'b0;  exp_s[1] = 1'b1;  exp_s[2] = 1'b1;
        bus0.s_ready = 1'b1; bus0.out0_ready = 1'b1; bus0.out1_ready = 1'b1;
        for (int k = 0; k <= 3; k++) begin
            @(negedge CLK);
            bus0.in_valid = (k < 3);
            bus0.in_data  = (k < 3) ? pkts[k] : 9'h000;
            #1;
            if (k < 3) begin
                n_cmp++;
                if (bus0.in_ready !== 1'b1) begin
                    n_err++; $display("FAIL b2b_ready pkt %0d: got %b want 1", k, bus0.in_ready);
                end
            end
            if (k > 0) begin
                got_s = bus0.s_data;
                got_b = bus0.out1_valid;
                got_d = bus0.out1_valid ? bus0.out1_data : bus0.out0_data;
                n_cmp++;
                if (bus0.s_valid !== 1'b1 || got_s !== exp_s[k-1] || got_b !== exp_s[k-1] ||
                    (bus0.out0_valid ^ bus0.out1_valid) !== 1'b1 || got_d !== pkts[k-1]) begin
                    n_err++;
                    $display("FAIL b2b_out pkt %0d: got sv=%b s=%b branch=%b data=%h want 1 %b %b %h",
                        k-1, bus0.s_valid, got_s, got_b, got_d, exp_s[k-1], exp_s[k-1], pkts[k-1]);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [9:0] sq[$];
        logic [9:0] dq[$];
        logic [9:0] e;
        logic [8:0] cur;
        bit         holding, prev_acc, prev_sel, did_reset, stop;
        int         n_acc, cyc;
        holding = 0; prev_acc = 0; prev_sel = 0; did_reset = 0; stop = 0;
        n_acc = 0; cur = '0;
        for (cyc = 0; cyc < 70000 && !stop && (n_acc < 10000 || sq.size() > 0 || dq.size() > 0); cyc++) begin
            @(negedge CLK);
            if (n_acc >= 5000 && !did_reset) begin
                rst_n = 1'b0; bus0.in_valid = 1'b0; #1;
                n_cmp++;
                if ({bus0.in_ready, bus0.s_valid, bus0.out0_valid, bus0.out1_valid} !== 4'b0) begin
                    n_err++; stop = 1;
                    $display("FAIL rand_midreset: got rdy/valids %b%b%b%b want 0000",
                        bus0.in_ready, bus0.s_valid, bus0.out0_valid, bus0.out1_valid);
                end
                sq.delete(); dq.delete();
                holding = 0; prev_acc = 0; did_reset = 1;
                repeat (3) @(negedge CLK);
                rst_n = 1'b1;
                continue;
            end
            if (!holding && n_acc < 10000 && $urandom_range(0, 3) != 0) begin
                cur = 9'($urandom);
                holding = 1;
            end
            bus0.in_valid = holding;
            bus0.in_data  = holding ? cur : 9'($urandom);
            bus0.s_ready    = (n_acc >= 10000) || ($urandom_range(0, 4) != 0);
            bus0.out0_ready = (n_acc >= 10000) || ($urandom_range(0, 4) != 0);
            bus0.out1_ready = (n_acc >= 10000) || ($urandom_range(0, 4) != 0);
            #1;
            if (prev_acc) begin
                n_cmp++;
                if (bus0.s_valid !== 1'b1 || (prev_sel ? bus0.out1_valid : bus0.out0_valid) !== 1'b1) begin
                    n_err++; stop = 1;
                    $display("FAIL rand_latency cycle %0d: got sv=%b v0=%b v1=%b want sv=1 on branch %b",
                        cyc, bus0.s_valid, bus0.out0_valid, bus0.out1_valid, prev_sel);
                end
            end
            if (bus0.s_valid && bus0.s_ready) begin
                n_cmp++;
                if (sq.size() == 0) begin
                    n_err++; stop = 1;
                    $display("FAIL rand_s_extra cycle %0d: got S token %b want none", cyc, bus0.s_data);
                end else begin
                    e = sq.pop_front();
                    if (bus0.s_data !== e[9]) begin
                        n_err++; stop = 1;
                        $display("FAIL rand_s cycle %0d: got %b want %b (pkt %h)", cyc, bus0.s_data, e[9], e[8:0]);
                    end
                end
            end
            if ((bus0.out0_valid && bus0.out0_ready) || (bus0.out1_valid && bus0.out1_ready)) begin
                n_cmp++;
                if (dq.size() == 0 || (bus0.out0_valid && bus0.out1_valid)) begin
                    n_err++; stop = 1;
                    $display("FAIL rand_d_extra cycle %0d: got v0=%b v1=%b want one expected token",
                        cyc, bus0.out0_valid, bus0.out1_valid);
                end else begin
                    e = dq.pop_front();
                    if (bus0.out1_valid !== e[9] ||
                        (bus0.out1_valid ? bus0.out1_data : bus0.out0_data) !== e[8:0]) begin
                        n_err++; stop = 1;
                        $display("FAIL rand_data cycle %0d: got branch=%b data=%h want branch=%b data=%h", cyc,
                            bus0.out1_valid, bus0.out1_valid ? bus0.out1_data : bus0.out0_data, e[9], e[8:0]);
                    end
                end
            end
            prev_acc = 0;
            if (holding && bus0.in_ready) begin
                prev_sel = golden_sel(cur, 1'b0);
                prev_acc = 1;
                sq.push_back({prev_sel, cur});
                dq.push_back({prev_sel, cur});
                holding = 0;
                n_acc++;
            end
        end
        bus0.in_valid = 1'b0;
        if (!stop) begin
            n_cmp++;
            if (n_acc != 10000 || sq.size() != 0 || dq.size() != 0 || !did_reset) begin
                n_err++;
                $display("FAIL rand_complete: got accepted=%0d s_left=%0d d_left=%0d reset=%0d want 10000 0 0 1",
                    n_acc, sq.size(), dq.size(), did_reset);
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_route();
        test_leaf();
        test_stall();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
